// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read-port register file, hardwired-zero entry 0, async
//               reads, optional write bypass, debug port, bulk-clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wn,
    input  logic [DATA_W-1:0]        d,
    input  logic [NREAD*ADDR_W-1:0]  rn,
    output logic [NREAD*DATA_W-1:0]  q,
    input  logic [ADDR_W-1:0]        reg_addr,
    output logic [DATA_W-1:0]        reg_out,
    input  logic                     init_req,
    output logic                     busy,
    output logic                     init_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              w_wr_en;
    logic              w_clearing;
    logic [DATA_W-1:0] w_rd [DEPTH];

    assign w_clearing = (r_state == ST_CLEAR);
    // External writes are locked out only while the clear sweep owns the array.
    assign w_wr_en    = we && !w_clearing && (wn != '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (init_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (&r_ptr) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Both status outputs decode the state register directly, so neither
    // has a combinational path from any input.
    assign busy      = (r_state == ST_CLEAR);
    assign init_done = (r_state == ST_DONE);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (i == 0) begin : g_zero
            assign w_rd[i] = '0;
        end else begin : g_reg
            logic [DATA_W-1:0] r_val;
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_val <= '0;
                end else if (w_clearing && (r_ptr == ADDR_W'(i))) begin
                    r_val <= '0;
                end else if (w_wr_en && (wn == ADDR_W'(i))) begin
                    r_val <= d;
                end
            end
            assign w_rd[i] = r_val;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = rn[k*ADDR_W +: ADDR_W];
        if (BYPASS != 0) begin : g_byp
            assign q[k*DATA_W +: DATA_W] = (w_wr_en && (w_ra == wn)) ? d : w_rd[w_ra];
        end else begin : g_nobyp
            assign q[k*DATA_W +: DATA_W] = w_rd[w_ra];
        end
    end

    assign reg_out = w_rd[reg_addr];

endmodule
`default_nettype wire
